crddrop_arb: RTL and testbench
==============================

CRDDROP_ARB -- requirements
Module: crddrop_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one crddrop unit; legal range 2..4.
REQ-002 Parameter DATA_W, default 17, stream word width; bit DATA_W-1 is the token flag.
REQ-003 Ports: one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 clk_en  in  1  state-advance enable.
REQ-007 flush  in  1  synchronous soft reset.
REQ-008 tile_en  in  1  block enable.
REQ-009 req_in_0/_1 [NUM_REQ]  in  DATA_W  per-requester value/coordinate input words, each with _valid in / _ready out.
REQ-010 req_out_0/_1 [NUM_REQ]  out  DATA_W  per-requester output words, each with _valid out / _ready in.
REQ-011 sh_in_0/_1  out  DATA_W  words to the shared unit's coord_in_0/_1, each with _valid out / _ready in.
REQ-012 sh_out_0/_1  in  DATA_W  words from the shared unit's coord_out_0/_1, each with _valid in / _ready out.
REQ-013 grant  out  NUM_REQ  one-hot owner of the shared unit; all zeros when idle.

Function
REQ-014 FSM states: IDLE, FEED, DRAIN.
REQ-015 IDLE: grant the first requester with req_in_0_valid or req_in_1_valid, searching round-robin from rr_ptr; move to FEED on the next cycle.
REQ-016 IDLE with no valid requester: stay in IDLE, grant = 0.
REQ-017 FEED: sh_in_k = req_in_k[owner]; sh_in_k_valid = owner valid AND NOT in_done[k]; req_in_k_ready[owner] = sh_in_k_ready AND NOT in_done[k].
REQ-018 Non-owner input readies SHALL be 0.
REQ-019 in_done[k] sets on the cycle a word equal to DONE_TOKEN 17'h10100 handshakes on sh_in_k; other tokens (bit16 = 1) pass through unchanged.
REQ-020 FEED to DRAIN when both in_done bits are set, including both setting in the same cycle.
REQ-021 FEED and DRAIN: req_out_k[owner] = sh_out_k; owner valid = sh_out_k_valid AND NOT out_done[k]; sh_out_k_ready = owner ready AND NOT out_done[k].
REQ-022 Non-owner output valids SHALL be 0.
REQ-023 out_done[k] sets on a DONE_TOKEN handshake on sh_out_k; this may occur while still in FEED.
REQ-024 DRAIN to IDLE when both out_done bits are set: clear the done bits, rr_ptr = owner+1 mod NUM_REQ, grant = 0.
REQ-025 Latency: combinational pass-through on the data paths; one cycle from IDLE grant decision to first forwarded handshake.
REQ-026 clk_en = 0: all state frozen; all readies and valids driven 0.
REQ-027 tile_en = 0: all readies and valids driven 0; state held.
REQ-028 Each in_done bit and out_done bit sets at most once per grant.

Reset
REQ-029 rst_n low asynchronously: state IDLE, grant 0, rr_ptr 0, done bits 0, all valid/ready outputs 0, data outputs 0.
REQ-030 flush high at an enabled edge: same values as reset, taking effect at that edge, including mid-FEED/DRAIN (any partial stream is abandoned).

Configuration
REQ-031 Macro CRDDROP_ARB_PERF_EN: when defined, adds output perf_busy [NUM_REQ] x 32, where each counter counts cycles that requester holds grant, saturating at 32'hFFFFFFFF.
REQ-032 perf_busy is cleared by reset and flush.
REQ-033 CRDDROP_ARB_PERF_EN not defined: no counters and no perf_busy port; all other behaviour identical.

Structure
REQ-034 Package sparse_arb_pkg holds DATA_W, DONE_TOKEN, the token-flag bit index, and the state enum.
REQ-035 One sub-module, rr_pick: combinational round-robin selector (request vector, pointer in; one-hot grant out).

Verification
REQ-036 Req0 streams coords 0,1,17'h10000,17'h10100 on both channels, req1 idle -> grant = 01, shared unit outputs forwarded only to req0, return to IDLE after output DONE on both channels, rr_ptr = 1.
REQ-037 Both requesters valid in the same cycle from reset -> req0 served first, then req1; grant sequence 01,00,10.
REQ-038 Shared output ready held low 20 cycles during DRAIN -> FSM stays in DRAIN, no word lost or duplicated, req1 input ready stays 0.
REQ-039 Input DONE on channel 0 ten cycles before channel 1 -> channel 0 ready drops after its DONE, FSM enters DRAIN only after channel 1 DONE.
REQ-040 flush asserted mid-FEED -> next cycle IDLE, grant 0, rr_ptr 0; a fresh req1 stream then completes correctly.
REQ-041 With CRDDROP_ARB_PERF_EN, req0 holding grant for 37 cycles -> perf_busy[0] = 37, perf_busy[1] = 0.

Source files
------------

// File: rtl/sparse_arb_pkg.sv
// Shared constants and FSM state type for the crddrop arbiter.
package sparse_arb_pkg;

    localparam int DATA_W = 17;
    localparam int TOKEN_BIT = DATA_W - 1;
    localparam logic [DATA_W-1:0] DONE_TOKEN = 17'h10100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/crddrop_arb_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr wins.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt = '0;
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % 32'(N));
            if (gnt == '0 && req[idx]) begin
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crddrop_arb.sv
// Arbitrates NUM_REQ two-channel coordinate streams onto one shared crddrop unit.
// Optional macro CRDDROP_ARB_PERF_EN adds per-requester busy-cycle counters (perf_busy).
module crddrop_arb #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = sparse_arb_pkg::DATA_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clk_en,
    input  logic                            flush,
    input  logic                            tile_en,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_in_0,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_in_1,
    input  logic [NUM_REQ-1:0]              req_in_0_valid,
    input  logic [NUM_REQ-1:0]              req_in_1_valid,
    output logic [NUM_REQ-1:0]              req_in_0_ready,
    output logic [NUM_REQ-1:0]              req_in_1_ready,
    output logic [NUM_REQ-1:0][DATA_W-1:0]  req_out_0,
    output logic [NUM_REQ-1:0][DATA_W-1:0]  req_out_1,
    output logic [NUM_REQ-1:0]              req_out_0_valid,
    output logic [NUM_REQ-1:0]              req_out_1_valid,
    input  logic [NUM_REQ-1:0]              req_out_0_ready,
    input  logic [NUM_REQ-1:0]              req_out_1_ready,
    output logic [DATA_W-1:0]               sh_in_0,
    output logic [DATA_W-1:0]               sh_in_1,
    output logic                            sh_in_0_valid,
    output logic                            sh_in_1_valid,
    input  logic                            sh_in_0_ready,
    input  logic                            sh_in_1_ready,
    input  logic [DATA_W-1:0]               sh_out_0,
    input  logic [DATA_W-1:0]               sh_out_1,
    input  logic                            sh_out_0_valid,
    input  logic                            sh_out_1_valid,
    output logic                            sh_out_0_ready,
    output logic                            sh_out_1_ready,
    output logic [NUM_REQ-1:0]              grant
`ifdef CRDDROP_ARB_PERF_EN
    ,
    output logic [NUM_REQ-1:0][31:0]        perf_busy
`endif
);

    import sparse_arb_pkg::*;

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [DATA_W-1:0] DONE_W = DATA_W'(sparse_arb_pkg::DONE_TOKEN);

    state_t            state;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     rr_ptr;
    logic [1:0]        in_done;
    logic [1:0]        out_done;
    logic [NUM_REQ-1:0] pick;
    logic [PW-1:0]     pick_idx;
    logic [1:0]        in_set;
    logic [1:0]        out_set;
    logic              feed_act;
    logic              out_act;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req (req_in_0_valid | req_in_1_valid),
        .ptr (rr_ptr),
        .gnt (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (pick[r]) pick_idx = PW'(r);
        end
    end

    assign feed_act = clk_en && tile_en && state == FEED;
    assign out_act  = clk_en && tile_en && (state == FEED || state == DRAIN);

    // grant is zero outside FEED/DRAIN, so it doubles as the per-requester route mask.
    always_comb begin
        sh_in_0        = (state == FEED) ? req_in_0[owner] : '0;
        sh_in_1        = (state == FEED) ? req_in_1[owner] : '0;
        sh_in_0_valid  = feed_act && |(req_in_0_valid & grant) && !in_done[0];
        sh_in_1_valid  = feed_act && |(req_in_1_valid & grant) && !in_done[1];
        sh_out_0_ready = out_act && |(req_out_0_ready & grant) && !out_done[0];
        sh_out_1_ready = out_act && |(req_out_1_ready & grant) && !out_done[1];
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            req_in_0_ready[r]  = feed_act && grant[r] && sh_in_0_ready && !in_done[0];
            req_in_1_ready[r]  = feed_act && grant[r] && sh_in_1_ready && !in_done[1];
            req_out_0[r]       = grant[r] ? sh_out_0 : '0;
            req_out_1[r]       = grant[r] ? sh_out_1 : '0;
            req_out_0_valid[r] = out_act && grant[r] && sh_out_0_valid && !out_done[0];
            req_out_1_valid[r] = out_act && grant[r] && sh_out_1_valid && !out_done[1];
        end
    end

    assign in_set[0]  = sh_in_0_valid && sh_in_0_ready && sh_in_0 == DONE_W;
    assign in_set[1]  = sh_in_1_valid && sh_in_1_ready && sh_in_1 == DONE_W;
    assign out_set[0] = sh_out_0_valid && sh_out_0_ready && sh_out_0 == DONE_W;
    assign out_set[1] = sh_out_1_valid && sh_out_1_ready && sh_out_1 == DONE_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            in_done  <= '0;
            out_done <= '0;
        end else if (clk_en) begin
            if (flush) begin
                state    <= IDLE;
                grant    <= '0;
                owner    <= '0;
                rr_ptr   <= '0;
                in_done  <= '0;
                out_done <= '0;
            end else if (tile_en) begin
                case (state)
                    IDLE: begin
                        if (|pick) begin
                            grant <= pick;
                            owner <= pick_idx;
                            state <= FEED;
                        end
                    end
                    FEED: begin
                        in_done  <= in_done | in_set;
                        out_done <= out_done | out_set;
                        if (&(in_done | in_set)) state <= DRAIN;
                    end
                    DRAIN: begin
                        if (&(out_done | out_set)) begin
                            state    <= IDLE;
                            grant    <= '0;
                            in_done  <= '0;
                            out_done <= '0;
                            rr_ptr   <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                        end else begin
                            out_done <= out_done | out_set;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef CRDDROP_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy <= '0;
        end else if (clk_en) begin
            if (flush) begin
                perf_busy <= '0;
            end else begin
                for (int unsigned r = 0; r < NUM_REQ; r++) begin
                    if (grant[r] && perf_busy[r] != '1) perf_busy[r] <= perf_busy[r] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_crddrop_arb.sv
// Directed self-checking bench for crddrop_arb (default two requesters, 17-bit words).
module tb_crddrop_arb;

    localparam int N = 2;
    localparam int W = 17;
    localparam logic [W-1:0] DONE = 17'h10100;

    logic clk = 1'b0;
    logic rst_n, clk_en, flush, tile_en;
    logic [N-1:0][W-1:0] req_in_0, req_in_1, req_out_0, req_out_1;
    logic [N-1:0] req_in_0_valid, req_in_1_valid, req_in_0_ready, req_in_1_ready;
    logic [N-1:0] req_out_0_valid, req_out_1_valid, req_out_0_ready, req_out_1_ready;
    logic [W-1:0] sh_in_0, sh_in_1, sh_out_0, sh_out_1;
    logic sh_in_0_valid, sh_in_1_valid, sh_in_0_ready, sh_in_1_ready;
    logic sh_out_0_valid, sh_out_1_valid, sh_out_0_ready, sh_out_1_ready;
    logic [N-1:0] grant;
`ifdef CRDDROP_ARB_PERF_EN
    logic [N-1:0][31:0] perf_busy;
`endif

    int n_chk = 0;
    int n_pass = 0;
    logic [W-1:0] seq [4];

    always #5 clk = ~clk;

    crddrop_arb #(
        .NUM_REQ (N),
        .DATA_W  (W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_en          (clk_en),
        .flush           (flush),
        .tile_en         (tile_en),
        .req_in_0        (req_in_0),
        .req_in_1        (req_in_1),
        .req_in_0_valid  (req_in_0_valid),
        .req_in_1_valid  (req_in_1_valid),
        .req_in_0_ready  (req_in_0_ready),
        .req_in_1_ready  (req_in_1_ready),
        .req_out_0       (req_out_0),
        .req_out_1       (req_out_1),
        .req_out_0_valid (req_out_0_valid),
        .req_out_1_valid (req_out_1_valid),
        .req_out_0_ready (req_out_0_ready),
        .req_out_1_ready (req_out_1_ready),
        .sh_in_0         (sh_in_0),
        .sh_in_1         (sh_in_1),
        .sh_in_0_valid   (sh_in_0_valid),
        .sh_in_1_valid   (sh_in_1_valid),
        .sh_in_0_ready   (sh_in_0_ready),
        .sh_in_1_ready   (sh_in_1_ready),
        .sh_out_0        (sh_out_0),
        .sh_out_1        (sh_out_1),
        .sh_out_0_valid  (sh_out_0_valid),
        .sh_out_1_valid  (sh_out_1_valid),
        .sh_out_0_ready  (sh_out_0_ready),
        .sh_out_1_ready  (sh_out_1_ready),
        .grant           (grant)
`ifdef CRDDROP_ARB_PERF_EN
        ,
        .perf_busy       (perf_busy)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        seq[0] = 17'h00000; seq[1] = 17'h00001; seq[2] = 17'h10000; seq[3] = DONE;
        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1;
        req_in_0 = '0; req_in_1 = '0; req_in_0_valid = 2'b01; req_in_1_valid = 2'b01;
        req_out_0_ready = 2'b11; req_out_1_ready = 2'b11;
        sh_in_0_ready = 1'b1; sh_in_1_ready = 1'b1;
        sh_out_0 = '0; sh_out_1 = '0; sh_out_0_valid = 1'b1; sh_out_1_valid = 1'b1;
        #12;
        chk("rst_grant", grant, 0);
        chk("rst_in_ready", {req_in_1_ready, req_in_0_ready}, 0);
        chk("rst_sh_valid", {sh_in_1_valid, sh_in_0_valid}, 0);
        chk("rst_sh_data", {sh_in_1, sh_in_0}, 0);
        chk("rst_out_valid", {req_out_1_valid, req_out_0_valid}, 0);
        chk("rst_sh_ready", {sh_out_1_ready, sh_out_0_ready}, 0);
        req_in_0_valid = '0; req_in_1_valid = '0; sh_out_0_valid = 1'b0; sh_out_1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single req0 stream on both channels
        req_in_0_valid = 2'b01; req_in_1_valid = 2'b01;
        #1;
        chk("a_idle_ready", {req_in_1_ready, req_in_0_ready}, 0);
        tick();
        chk("a_grant", grant, 2'b01);
        chk("a_in_ready", {req_in_1_ready, req_in_0_ready}, 4'b0101);
        for (int i = 0; i < 4; i++) begin
            req_in_0[0] = seq[i]; req_in_1[0] = seq[i];
            #1;
            chk("a_fwd0", sh_in_0, seq[i]);
            chk("a_fwd1", sh_in_1, seq[i]);
            tick();
        end
        req_in_0_valid = '0; req_in_1_valid = '0;
        #1;
        chk("a_drain_in_ready", {req_in_1_ready, req_in_0_ready}, 0);
        chk("a_drain_grant", grant, 2'b01);
        sh_out_0 = 17'h5; sh_out_1 = 17'h9; sh_out_0_valid = 1'b1; sh_out_1_valid = 1'b1;
        #1;
        chk("a_out0", req_out_0, {17'h0, 17'h5});
        chk("a_out1", req_out_1, {17'h0, 17'h9});
        chk("a_out_valid", {req_out_1_valid, req_out_0_valid}, 4'b0101);
        chk("a_sh_ready", {sh_out_1_ready, sh_out_0_ready}, 2'b11);
        tick();
        sh_out_0 = DONE; sh_out_1 = DONE;
        #1;
        tick();
        sh_out_0_valid = 1'b0; sh_out_1_valid = 1'b0;
        #1;
        chk("a_end_grant", grant, 0);
        chk("a_end_sh_ready", {sh_out_1_ready, sh_out_0_ready}, 0);

        // pointer advanced to 1: req1 wins a tie
        req_in_0[0] = 17'h3; req_in_0[1] = 17'h3; req_in_0_valid = 2'b11;
        tick();
        chk("rr_grant", grant, 2'b10);
        #2; rst_n = 1'b0; #1;
        chk("async_grant", grant, 0);
        chk("async_ready", {req_in_1_ready, req_in_0_ready}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // tie from reset: req0 first, then req1
        #1;
        chk("b_idle", grant, 0);
        tick();
        chk("b_g1", grant, 2'b01);
        chk("b_nonowner_ready", req_in_0_ready, 2'b01);
        req_in_0[0] = DONE; req_in_1[0] = DONE; req_in_1_valid = 2'b01;
        #1;
        tick();
        sh_out_0 = DONE; sh_out_1 = DONE; sh_out_0_valid = 1'b1; sh_out_1_valid = 1'b1;
        #1;
        tick();
        chk("b_g2", grant, 2'b00);
        sh_out_0_valid = 1'b0; sh_out_1_valid = 1'b0;
        req_in_0_valid = 2'b10; req_in_1_valid = 2'b10;
        req_in_0[1] = DONE; req_in_1[1] = 17'h2;
        tick();
        chk("b_g3", grant, 2'b10);

        // channel 0 finishes ten words ahead of channel 1
        chk("c_rdy_pre", {req_in_1_ready, req_in_0_ready}, 4'b1010);
        tick();
        chk("c_rdy0_drop", req_in_0_ready, 0);
        chk("c_rdy1", req_in_1_ready, 2'b10);
        chk("c_shv0", sh_in_0_valid, 0);
        for (int i = 0; i < 9; i++) begin
            req_in_1[1] = 17'h10000 | W'(i);
            #1;
            chk("c_fwd", sh_in_1, 17'h10000 | W'(i));
            chk("c_feed", req_in_1_ready, 2'b10);
            tick();
        end
        req_in_1[1] = DONE;
        #1;
        chk("c_pre_drain", req_in_1_ready, 2'b10);
        tick();
        chk("c_drain", {req_in_1_ready, req_in_0_ready}, 0);
        req_in_0_valid = '0; req_in_1_valid = '0;

        // requester output stalled for 20 cycles in DRAIN
        req_out_0_ready = '0; req_out_1_ready = '0;
        sh_out_0 = 17'h11; sh_out_1 = 17'h22; sh_out_0_valid = 1'b1; sh_out_1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("d_sh_rdy", {sh_out_1_ready, sh_out_0_ready}, 0);
            chk("d_fwd", req_out_0[1], 17'h11);
            chk("d_in_rdy", {req_in_1_ready, req_in_0_ready}, 0);
            tick();
        end
        chk("d_state", grant, 2'b10);
        req_out_0_ready = 2'b10; req_out_1_ready = 2'b10;
        #1;
        chk("d_valid", {req_out_1_valid, req_out_0_valid}, 4'b1010);
        chk("d_rdy", {sh_out_1_ready, sh_out_0_ready}, 2'b11);
        chk("d_word1", req_out_1[1], 17'h22);
        tick();
        sh_out_0 = DONE; sh_out_1 = DONE;
        #1;
        chk("d_fwd_done", req_out_0[1], DONE);
        tick();
        chk("d_idle", grant, 0);
        sh_out_0_valid = 1'b0; sh_out_1_valid = 1'b0;
        req_out_0_ready = 2'b11; req_out_1_ready = 2'b11;

        // enables, then flush mid-FEED
        req_in_0[0] = 17'h5; req_in_1[0] = 17'h5; req_in_0_valid = 2'b01; req_in_1_valid = 2'b01;
        tick();
        chk("e_grant", grant, 2'b01);
        clk_en = 1'b0;
        #1;
        chk("f_clken_rdy", {req_in_1_ready, req_in_0_ready}, 0);
        chk("f_clken_v", {sh_in_1_valid, sh_in_0_valid}, 0);
        tick();
        clk_en = 1'b1;
        #1;
        chk("f_clken_hold", grant, 2'b01);
        chk("f_clken_rdy_back", {req_in_1_ready, req_in_0_ready}, 4'b0101);
        tile_en = 1'b0;
        #1;
        chk("f_tile_rdy", {req_in_1_ready, req_in_0_ready}, 0);
        chk("f_tile_v", {sh_in_1_valid, sh_in_0_valid}, 0);
        tick();
        tile_en = 1'b1;
        #1;
        chk("f_tile_hold", grant, 2'b01);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req_in_0_valid = '0; req_in_1_valid = '0;
        #1;
        chk("e_flush_grant", grant, 0);
        chk("e_flush_ptr", dut.rr_ptr, 0);
        chk("e_flush_v", {sh_in_1_valid, sh_in_0_valid}, 0);
        req_in_0[1] = 17'h7; req_in_1[1] = 17'h8; req_in_0_valid = 2'b10; req_in_1_valid = 2'b10;
        tick();
        chk("e_g", grant, 2'b10);
        #1;
        chk("e_fwd", {sh_in_1, sh_in_0}, {17'h8, 17'h7});
        tick();
        req_in_0[1] = DONE; req_in_1[1] = DONE;
        #1;
        tick();
        chk("e_drain", {req_in_1_ready, req_in_0_ready}, 0);
        req_in_0_valid = '0; req_in_1_valid = '0;
        sh_out_0 = DONE; sh_out_1 = 17'h3; sh_out_0_valid = 1'b1; sh_out_1_valid = 1'b1;
        #1;
        chk("e_out", req_out_1, {17'h3, 17'h0});
        tick();
        chk("e_mask", req_out_0_valid, 0);
        chk("e_still", grant, 2'b10);
        sh_out_1 = DONE;
        #1;
        tick();
        chk("e_end", grant, 0);
        chk("e_end_ptr", dut.rr_ptr, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
